// File: rtl/mole_ctrl_pkg.sv
// Shared types and widths for the whack-a-mole round controller.
// State encoding, output widths and the phase-length helper live here.
package mole_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_MOLE_UP   = 3'd2,
    ST_MOLE_DOWN = 3'd3,
    ST_PAUSED    = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam int SEC_W         = 7;
  localparam int RDY_W         = 4;
  localparam int MS_W          = 10;
  localparam int PH_W          = 16;
  localparam int MAX_LEVEL_DEF = 7;
  localparam int LW            = $clog2(MAX_LEVEL_DEF + 1);

  // Phase length shrinks by step per level but never drops below the floor.
  function automatic logic [PH_W-1:0] phase_ms(input int base, input int lvl,
                                               input int step, input int min_ms);
    int len;
    len = base - lvl * step;
    if (len < min_ms) len = min_ms;
    return PH_W'(len);
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk down to a one-cycle millisecond tick, firing on the counter wrap.
// Count advances while enabled, holds when neither enabled nor cleared.
module ms_prescaler #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer for a whack-a-mole game: countdown, mole up/down phases, levels, pause.
// All outputs registered; every input takes effect on the next clock edge.
module mole_round_controller
  import mole_ctrl_pkg::*;
#(
  parameter int CLK_PER_MS     = 50000,
  parameter int GAME_LENGTH_S  = 20,
  parameter int READY_S        = 3,
  parameter int MOLE_UP_MS     = 1000,
  parameter int MOLE_DOWN_MS   = 1000,
  parameter int STEP_MS        = 100,
  parameter int MIN_MS         = 300,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_pressed,
  input  logic                           pause_pressed,
  input  logic                           hit,
  input  logic                           miss,
  output logic                           game_in_progress,
  output logic                           mole_clk,
  output logic                           mole_up,
  output logic [SEC_W-1:0]               seconds_left,
  output logic [RDY_W-1:0]               ready_count,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           game_over
);

  localparam int LVW = $clog2(MAX_LEVEL + 1);
  localparam int SKW = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(999);
  localparam logic [LVW-1:0]  LV_MAX  = LVW'(MAX_LEVEL);
  localparam logic [SKW-1:0]  SK_TOP  = SKW'(HITS_PER_LEVEL);

  state_t state, state_nxt, saved;

  logic            running, in_play, start_ok;
  logic            prescale_en, prescale_clr, tick;
  logic            sec_wrap, phase_done, enter_phase, mole_clk_nxt;
  logic [MS_W-1:0] ms_in_sec;
  logic [PH_W-1:0] phase_cnt, phase_len;
  logic [RDY_W-1:0] ready, ready_nxt;
  logic [LVW-1:0]  level_nxt;
  logic [SKW-1:0]  streak, streak_nxt;

  assign running  = state inside {ST_COUNTDOWN, ST_MOLE_UP, ST_MOLE_DOWN};
  assign in_play  = state inside {ST_MOLE_UP, ST_MOLE_DOWN};
  assign start_ok = (state == ST_IDLE || state == ST_GAME_OVER) && start_pressed;

  // The pause cycle itself is not counted, so a phase resumes exactly where it stopped.
  assign prescale_en  = running && !pause_pressed;
  assign prescale_clr = !running && (state != ST_PAUSED);

  ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .enable(prescale_en),
    .clear (prescale_clr),
    .tick  (tick)
  );

  assign sec_wrap   = tick && (ms_in_sec == MS_LAST);
  assign phase_done = tick && (phase_cnt == phase_len - PH_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      saved            <= ST_IDLE;
      game_in_progress <= 1'b0;
      mole_clk         <= 1'b0;
      mole_up          <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_PAUSED && state != ST_PAUSED) saved <= state;
      game_in_progress <= state_nxt inside {ST_COUNTDOWN, ST_MOLE_UP, ST_MOLE_DOWN, ST_PAUSED};
      mole_clk         <= mole_clk_nxt;
      mole_up          <= (state_nxt == ST_MOLE_UP);
      game_over        <= (state_nxt == ST_GAME_OVER);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_pressed) state_nxt = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (pause_pressed)                           state_nxt = ST_PAUSED;
        else if (sec_wrap && ready == RDY_W'(1))     state_nxt = ST_MOLE_UP;
      end
      ST_MOLE_UP: begin
        if (pause_pressed)                           state_nxt = ST_PAUSED;
        else if (sec_wrap && seconds_left == SEC_W'(1)) state_nxt = ST_GAME_OVER;
        else if (phase_done)                         state_nxt = ST_MOLE_DOWN;
      end
      ST_MOLE_DOWN: begin
        if (pause_pressed)                           state_nxt = ST_PAUSED;
        else if (sec_wrap && seconds_left == SEC_W'(1)) state_nxt = ST_GAME_OVER;
        else if (phase_done)                         state_nxt = ST_MOLE_UP;
      end
      ST_PAUSED: begin
        if (pause_pressed) state_nxt = saved;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mole_clk_nxt = (state == ST_COUNTDOWN || state == ST_MOLE_DOWN) && (state_nxt == ST_MOLE_UP);
    enter_phase  = (state_nxt inside {ST_MOLE_UP, ST_MOLE_DOWN}) && (state_nxt != state)
                   && (state != ST_PAUSED);
  end

  always_comb begin
    level_nxt  = level;
    streak_nxt = streak;
    ready_nxt  = ready;
    if (in_play) begin
      if (miss) begin
        streak_nxt = '0;
      end else if (hit) begin
        if (streak + SKW'(1) == SK_TOP) begin
          streak_nxt = '0;
          if (level != LV_MAX) level_nxt = level + LVW'(1);
        end else begin
          streak_nxt = streak + SKW'(1);
        end
      end
    end
    if (start_ok)                                ready_nxt = RDY_W'(READY_S);
    else if (sec_wrap && state == ST_COUNTDOWN)  ready_nxt = ready - RDY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_in_sec    <= '0;
      ready        <= '0;
      ready_count  <= '0;
      seconds_left <= SEC_W'(GAME_LENGTH_S);
      level        <= '0;
      streak       <= '0;
      phase_cnt    <= '0;
      phase_len    <= phase_ms(MOLE_UP_MS, 0, STEP_MS, MIN_MS);
    end else begin
      ready       <= ready_nxt;
      ready_count <= (state_nxt == ST_COUNTDOWN) ? ready_nxt : '0;
      if (start_ok) begin
        ms_in_sec    <= '0;
        seconds_left <= SEC_W'(GAME_LENGTH_S);
        level        <= '0;
        streak       <= '0;
      end else begin
        level  <= level_nxt;
        streak <= streak_nxt;
        if (tick) ms_in_sec <= sec_wrap ? '0 : ms_in_sec + MS_W'(1);
        if (sec_wrap && in_play) seconds_left <= seconds_left - SEC_W'(1);
      end
      // Length is fixed at entry using the level that becomes visible with the new phase.
      if (enter_phase) begin
        phase_cnt <= '0;
        phase_len <= (state_nxt == ST_MOLE_UP)
                     ? phase_ms(MOLE_UP_MS,   int'(level_nxt), STEP_MS, MIN_MS)
                     : phase_ms(MOLE_DOWN_MS, int'(level_nxt), STEP_MS, MIN_MS);
      end else if (tick && in_play) begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end
    end
  end

endmodule
